// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues in-order imem reads for the current PC,
// buffers returned {pc, data} pairs for decode and squashes wrong-path work
// on a redirect.

package instr_fetch_pkg;
  localparam int unsigned XLEN = 16;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } ir_entry_t;
endpackage

module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic            redirect,
  output logic [XLEN-1:0] pc_nxt,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            ir_valid,
  output logic [XLEN-1:0] ir_data,
  output logic [XLEN-1:0] ir_pc,
  input  logic            ir_ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  // Outstanding/drop bookkeeping and both FIFO pointer sets
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] a_wr_q, a_wr_d, a_rd_q, a_rd_d;
  logic [PTR_W-1:0] i_wr_q, i_wr_d, i_rd_q, i_rd_d;
  ir_entry_t        head_q, head_d;

  logic [XLEN-1:0]  addr_mem [DEPTH];
  ir_entry_t        ir_mem   [DEPTH];

  logic             credit_ok;
  logic             fire;
  logic             resp;
  logic             ir_push;
  logic             ir_pop;
  ir_entry_t        push_entry;

  // Issue, PC feedback, response routing and next-state computation
  always_comb begin
    credit_ok  = (SUM_W'(outst_q) + SUM_W'(count_q)) < SUM_W'(DEPTH);
    imem_req   = rst && !redirect && credit_ok;
    imem_addr  = pc_in;
    fire       = imem_req && imem_gnt;
    pc_nxt     = !rst ? '0 : (fire ? pc_in + XLEN'(1) : pc_in);

    // A response with nothing outstanding is a protocol error; ignore it
    resp       = imem_rvalid && (outst_q != '0);
    ir_push    = resp && (drop_q == '0) && !redirect;
    ir_pop     = (count_q != '0) && ir_ready && !redirect;
    push_entry = '{pc: addr_mem[a_rd_q], data: imem_rdata};

    a_wr_d  = fire ? a_wr_q + PTR_W'(1) : a_wr_q;
    a_rd_d  = resp ? a_rd_q + PTR_W'(1) : a_rd_q;
    outst_d = outst_q + CNT_W'(fire) - CNT_W'(resp);

    drop_d = drop_q;
    if (redirect) begin
      drop_d = outst_q - CNT_W'(resp);
    end else if (resp && (drop_q != '0)) begin
      drop_d = drop_q - CNT_W'(1);
    end

    i_wr_d  = ir_push ? i_wr_q + PTR_W'(1) : i_wr_q;
    i_rd_d  = ir_pop  ? i_rd_q + PTR_W'(1) : i_rd_q;
    count_d = count_q + CNT_W'(ir_push) - CNT_W'(ir_pop);
    if (redirect) begin
      i_rd_d  = i_wr_q;
      i_wr_d  = i_wr_q;
      count_d = '0;
    end

    // Head register holds its last value whenever the buffer goes empty
    head_d = head_q;
    if (!redirect && (count_d != '0)) begin
      head_d = (ir_push && (i_wr_q == i_rd_d)) ? push_entry : ir_mem[i_rd_d];
    end
  end

  // Control state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      outst_q <= '0;
      drop_q  <= '0;
      count_q <= '0;
      a_wr_q  <= '0;
      a_rd_q  <= '0;
      i_wr_q  <= '0;
      i_rd_q  <= '0;
      head_q  <= '0;
    end else begin
      outst_q <= outst_d;
      drop_q  <= drop_d;
      count_q <= count_d;
      a_wr_q  <= a_wr_d;
      a_rd_q  <= a_rd_d;
      i_wr_q  <= i_wr_d;
      i_rd_q  <= i_rd_d;
      head_q  <= head_d;
    end
  end

  // FIFO storage; validity is tracked by the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (rst && fire) begin
      addr_mem[a_wr_q] <= pc_in;
    end
    if (rst && ir_push) begin
      ir_mem[i_wr_q] <= push_entry;
    end
  end

  assign ir_valid = (count_q != '0);
  assign ir_data  = head_q.data;
  assign ir_pc    = head_q.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: acts as program counter register and
// (optionally) as a 1-cycle-latency instruction memory.

module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic [15:0] pc_in;
  logic        redirect;
  logic [15:0] pc_nxt;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        ir_valid;
  logic [15:0] ir_data;
  logic [15:0] ir_pc;
  logic        ir_ready;

  int total;
  int bad;
  bit auto_mem;
  bit auto_pc;

  instr_fetch #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .redirect    (redirect),
    .pc_nxt      (pc_nxt),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .ir_valid    (ir_valid),
    .ir_data     (ir_data),
    .ir_pc       (ir_pc),
    .ir_ready    (ir_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle: sample the request, clock, then model PC register and memory
  task automatic step();
    logic        f;
    logic [15:0] a;
    logic [15:0] pn;
    f  = imem_req && imem_gnt;
    a  = imem_addr;
    pn = pc_nxt;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      imem_rvalid = f;
      imem_rdata  = a ^ 16'hA5A5;
    end
    if (auto_pc) pc_in = pn;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req cyc=%0d got=%b want=0", i, imem_req); end
      total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL rst_ir_valid cyc=%0d got=%b want=0", i, ir_valid); end
      total++; if (pc_nxt !== 16'h0000) begin bad++; $display("FAIL rst_pc_nxt cyc=%0d got=%h want=0000", i, pc_nxt); end
      if (i == 2) begin
        total++; if (ir_pc !== 16'h0000) begin bad++; $display("FAIL rst_ir_pc got=%h want=0000", ir_pc); end
        total++; if (ir_data !== 16'h0000) begin bad++; $display("FAIL rst_ir_data got=%h want=0000", ir_data); end
      end
      step();
    end
    rst = 1'b1;
    #1;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rel_req got=%b want=1", imem_req); end
    total++; if (imem_addr !== 16'h0000) begin bad++; $display("FAIL rel_addr got=%h want=0000", imem_addr); end
    total++; if (pc_nxt !== 16'h0001) begin bad++; $display("FAIL rel_pc_nxt got=%h want=0001", pc_nxt); end
    step();
  endtask

  task automatic test_streaming();
    logic [15:0] exp_pc;
    auto_mem = 1'b1;
    do_reset();
    pc_in    = 16'h0010;
    ir_ready = 1'b1;
    imem_gnt = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (c < 2) begin
        total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL stream_lat cyc=%0d got=%b want=0", c, ir_valid); end
      end else begin
        exp_pc = 16'h0010 + 16'(c - 2);
        total++; if (ir_valid !== 1'b1) begin bad++; $display("FAIL stream_valid cyc=%0d got=%b want=1", c, ir_valid); end
        total++; if (ir_pc !== exp_pc) begin bad++; $display("FAIL stream_pc cyc=%0d got=%h want=%h", c, ir_pc, exp_pc); end
        total++; if (ir_data !== (exp_pc ^ 16'hA5A5)) begin bad++; $display("FAIL stream_data cyc=%0d got=%h want=%h", c, ir_data, exp_pc ^ 16'hA5A5); end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int nf;
    auto_mem = 1'b1;
    do_reset();
    pc_in    = 16'h0020;
    ir_ready = 1'b0;
    imem_gnt = 1'b1;
    nf = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (imem_req && imem_gnt) nf++;
      step();
    end
    #1;
    total++; if (nf != 4) begin bad++; $display("FAIL bp_fires got=%0d want=4", nf); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_req got=%b want=0", imem_req); end
    total++; if (pc_nxt !== 16'h0024) begin bad++; $display("FAIL bp_pc_hold got=%h want=0024", pc_nxt); end
    total++; if (ir_pc !== 16'h0020) begin bad++; $display("FAIL bp_head got=%h want=0020", ir_pc); end
    ir_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (ir_valid !== 1'b1) begin bad++; $display("FAIL bp_drain_valid cyc=%0d got=%b want=1", c, ir_valid); end
      total++; if (ir_pc !== 16'h0020 + 16'(c)) begin bad++; $display("FAIL bp_drain_pc cyc=%0d got=%h want=%h", c, ir_pc, 16'h0020 + 16'(c)); end
      if (c == 1) begin
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL bp_resume got=%b want=1", imem_req); end
      end
      step();
    end
  endtask

  task automatic test_flush();
    auto_mem = 1'b0;
    do_reset();
    pc_in       = 16'h0030;
    ir_ready    = 1'b0;
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    step();
    imem_rvalid = 1'b1; imem_rdata = 16'h0030 ^ 16'hA5A5;
    step();
    imem_rdata = 16'h0031 ^ 16'hA5A5;
    step();
    imem_rvalid = 1'b0;
    step();
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL fl_full got=%b want=0", imem_req); end
    total++; if (ir_pc !== 16'h0030) begin bad++; $display("FAIL fl_head got=%h want=0030", ir_pc); end
    redirect    = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 16'h0032 ^ 16'hA5A5;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL fl_req_redirect got=%b want=0", imem_req); end
    step();
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    pc_in       = 16'h0100;
    #1;
    total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL fl_cleared got=%b want=0", ir_valid); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL fl_tgt_req got=%b want=1", imem_req); end
    total++; if (imem_addr !== 16'h0100) begin bad++; $display("FAIL fl_tgt_addr got=%h want=0100", imem_addr); end
    step();
    imem_rvalid = 1'b1; imem_rdata = 16'h0033 ^ 16'hA5A5;
    step();
    imem_rdata = 16'h0100 ^ 16'hA5A5;
    #1;
    total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL fl_stale_drop got=%b want=0", ir_valid); end
    step();
    imem_rvalid = 1'b0;
    #1;
    total++; if (ir_valid !== 1'b1) begin bad++; $display("FAIL fl_tgt_valid got=%b want=1", ir_valid); end
    total++; if (ir_pc !== 16'h0100) begin bad++; $display("FAIL fl_tgt_pc got=%h want=0100", ir_pc); end
    total++; if (ir_data !== 16'hA4A5) begin bad++; $display("FAIL fl_tgt_data got=%h want=a4a5", ir_data); end
    step();
    auto_mem = 1'b1;
  endtask

  task automatic test_wrap();
    auto_mem = 1'b1;
    do_reset();
    pc_in    = 16'hFFFF;
    ir_ready = 1'b1;
    imem_gnt = 1'b1;
    #1;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL wrap_req got=%b want=1", imem_req); end
    total++; if (pc_nxt !== 16'h0000) begin bad++; $display("FAIL wrap_pc_nxt got=%h want=0000", pc_nxt); end
    step();
    step();
    #1;
    total++; if (ir_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%b want=1", ir_valid); end
    total++; if (ir_pc !== 16'hFFFF) begin bad++; $display("FAIL wrap_ir_pc got=%h want=ffff", ir_pc); end
    total++; if (ir_data !== 16'h5A5A) begin bad++; $display("FAIL wrap_ir_data got=%h want=5a5a", ir_data); end
    step();
  endtask

  task automatic test_stall();
    auto_mem = 1'b1;
    do_reset();
    ir_ready = 1'b1;
    imem_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pc_in = 16'h0040 + 16'(i);
      #1;
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL stall_req cyc=%0d got=%b want=1", i, imem_req); end
      total++; if (pc_nxt !== 16'h0040 + 16'(i)) begin bad++; $display("FAIL stall_pc_nxt cyc=%0d got=%h want=%h", i, pc_nxt, 16'h0040 + 16'(i)); end
      step();
    end
    pc_in    = 16'h0050;
    imem_gnt = 1'b1;
    #1;
    step();
    imem_gnt = 1'b0;
    step();
    #1;
    total++; if (ir_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b want=1", ir_valid); end
    total++; if (ir_pc !== 16'h0050) begin bad++; $display("FAIL stall_tag got=%h want=0050", ir_pc); end
    total++; if (ir_data !== (16'h0050 ^ 16'hA5A5)) begin bad++; $display("FAIL stall_data got=%h want=%h", ir_data, 16'h0050 ^ 16'hA5A5); end
    step();
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    auto_mem    = 1'b1;
    auto_pc     = 1'b1;
    rst         = 1'b0;
    pc_in       = 16'h0000;
    redirect    = 1'b0;
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
    ir_ready    = 1'b1;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_wrap();
    test_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
